dca_mru_step_engine: RTL and testbench
======================================

// Module: dca_mru_step_engine
// PURPOSE
// - Parametrised matrix-register-update (MRU) step engine for the DCA datapath; next generation of the fixed 4-deep MRU step unit.
// - Accepts blocked step instructions; optionally transposes, fills or zeroes the source matrix; gates each step on LSU0 and fill handshakes.
// - Emits one registered write per step, with a per-element mask, to the matrix register file; sits between the step sequencer and the mreg.
// - Tracks outstanding writes with a binary credit counter and pulses done once the last step has drained.
// PARAMETERS
// - MATRIX_SIZE_PARA   8   DIM: matrix is DIM x DIM; NUM_ELEM = DIM*DIM
// - BW_SCALAR          16  element width; BW_MATRIX = NUM_ELEM*BW_SCALAR
// - MAX_OUTSTANDING    4   max unacknowledged writes (>=1); BW_CNT = $clog2(MAX_OUTSTANDING+1)
// - BW_DIM             4   width of active-region sizes; must satisfy 2^BW_DIM > DIM
// PORTS
// - clk             in   1          clock
// - rst             in   1          synchronous reset, active-high
// - step_valid      in   1          step instruction valid
// - step_ready      out  1          step accepted when step_valid & step_ready
// - step_opcode     in   4          [0] transpose, [1] fill, [2] lsu0_req, [3] zero
// - step_last       in   1          last step of the block
// - num_row         in   BW_DIM     active rows (0 = all DIM)
// - num_col         in   BW_DIM     active cols (0 = all DIM)
// - fill_valid      in   1          fill scalar available
// - fill_ready      out  1          fill scalar consumed
// - fill_value      in   BW_SCALAR  fill scalar
// - lsu_req_valid   out  1          LSU0 request issued
// - lsu_req_ready   in   1          LSU0 can accept
// - src_matrix      in   BW_MATRIX  row-major source, element (r,c) at index r*DIM+c
// - wvalid          out  1          write strobe to mreg
// - wdata           out  BW_MATRIX  write data
// - wenable         out  NUM_ELEM   per-element write mask
// - wresp           in   1          one write completed (1-cycle pulse)
// - busy            out  1          step in flight, or outstanding writes, or draining
// - done            out  1          1-cycle pulse at block completion
// - err_underflow   out  1          sticky; set on wresp while count==0
// BEHAVIOUR
// - Reset: all outputs 0; state=RUN; count=0; err_underflow=0. Reset mid-block discards all in-flight work with no done pulse.
// - States:
//   - RUN: normal operation.
//   - DRAIN: entered on acceptance with step_last=1.
//   - DONE: entered from DRAIN when count==0 and wvalid==0; lasts 1 cycle, done=1, then returns to RUN.
// - step_ready=1 only when all hold:
//   - state==RUN;
//   - credit: count<MAX_OUTSTANDING, or wresp this cycle;
//   - fill_valid if opcode[1];
//   - lsu_req_ready if opcode[2].
// - lsu_req_valid = step_valid & step_ready & opcode[2]; fill_ready = step_valid & step_ready & opcode[1]. Both are combinational, same cycle as acceptance.
// - Data select priority: zero > fill > transpose > pass-through.
//   - zero: all elements 0.
//   - fill: every element = fill_value.
//   - transpose: element (r,c) = src(c,r).
//   - pass-through: element (r,c) = src(r,c).
// - Mask: wenable[r*DIM+c] = (r<R)&(c<C), with R = num_row, or DIM when num_row==0; C likewise from num_col. Values >DIM are clamped to DIM.
// - Latency: wvalid/wdata/wenable are registered, 1 cycle after acceptance; wvalid is 1-cycle pulses, back-to-back allowed.
// - count: +1 on acceptance, -1 on wresp, unchanged if both occur. It never exceeds MAX_OUTSTANDING.
// - wresp with count==0 and no acceptance that cycle: count stays 0, err_underflow set. Only rst clears it.
// - busy = (state!=RUN) | (count!=0) | wvalid.
// CONFIGURATION
// - Macro DCA_MRU_STEP_STAT_EN, when defined, adds:
//   - outputs stat_steps[31:0] (accepted steps) and stat_stall[31:0] (cycles with step_valid & ~step_ready in RUN);
//   - both saturating counters, cleared by rst and at DONE.
// - Undefined: no such ports and no counters.
// TESTING
// - T1 passthrough: DIM=8, num_row=num_col=0, opcode=0, src ramp 0..63 -> wvalid 1 cycle later, wdata==src, wenable all ones.
// - T2 transpose+mask: opcode=1, num_row=3, num_col=2 -> wdata(r,c)=src(c,r); wenable has 1s only at r<3,c<2 (6 bits).
// - T3 credit stall: MAX_OUTSTANDING=4, wresp held 0, 6 valid steps -> exactly 4 accepted, step_ready=0. One wresp pulse -> 5th step accepted that cycle.
// - T4 handshakes: opcode=6 (fill+lsu), fill_value=0x00AB, lsu_req_ready=0 for 3 cycles -> no accept, fill_ready=0. Release -> single accept, all elements 0x00AB.
// - T5 drain: 3 steps, last flagged, 3 wresp pulses delayed 5 cycles -> step_ready=0 after last; done pulses exactly once, 1 cycle after count reaches 0 and wvalid=0.
// - T6 reset/error: wresp with count==0 -> err_underflow=1. rst mid-DRAIN -> err_underflow=0, count=0, no done pulse.

Source files
------------

// File: rtl/dca_mru_step_engine.sv
// Matrix-register-update step engine: selects/transposes/fills a source matrix, masks it to the
// active region and issues one registered mreg write per step. Optional macro DCA_MRU_STEP_STAT_EN adds step/stall counters.
module dca_mru_step_engine #(
    parameter int MATRIX_SIZE_PARA = 8,
    parameter int BW_SCALAR        = 16,
    parameter int MAX_OUTSTANDING  = 4,
    parameter int BW_DIM           = 4,
    localparam int NUM_ELEM        = MATRIX_SIZE_PARA * MATRIX_SIZE_PARA,
    localparam int BW_MATRIX       = NUM_ELEM * BW_SCALAR,
    localparam int BW_CNT          = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 step_valid,
    output logic                 step_ready,
    input  logic [3:0]           step_opcode,
    input  logic                 step_last,
    input  logic [BW_DIM-1:0]    num_row,
    input  logic [BW_DIM-1:0]    num_col,
    input  logic                 fill_valid,
    output logic                 fill_ready,
    input  logic [BW_SCALAR-1:0] fill_value,
    output logic                 lsu_req_valid,
    input  logic                 lsu_req_ready,
    input  logic [BW_MATRIX-1:0] src_matrix,
    output logic                 wvalid,
    output logic [BW_MATRIX-1:0] wdata,
    output logic [NUM_ELEM-1:0]  wenable,
    input  logic                 wresp,
    output logic                 busy,
    output logic                 done,
    output logic                 err_underflow
`ifdef DCA_MRU_STEP_STAT_EN
    ,
    output logic [31:0]          stat_steps,
    output logic [31:0]          stat_stall
`endif
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [BW_CNT-1:0] CNT_MAX = BW_CNT'(MAX_OUTSTANDING);
    localparam logic [BW_DIM-1:0] DIM_W   = BW_DIM'(MATRIX_SIZE_PARA);

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [BW_CNT-1:0]      count_r;
    logic                   err_r;
    logic                   wvalid_r;
    logic [BW_MATRIX-1:0]   wdata_r;
    logic [NUM_ELEM-1:0]    wenable_r;
    logic                   step_ready_s;
    logic                   accept_s;
    logic [BW_DIM-1:0]      rows_s;
    logic [BW_DIM-1:0]      cols_s;
    logic [BW_MATRIX-1:0]   data_s;
    logic [NUM_ELEM-1:0]    mask_s;

    // A size of zero means the full dimension; oversize requests saturate at the full dimension.
    function automatic logic [BW_DIM-1:0] eff_dim(input logic [BW_DIM-1:0] n);
        if ((n == {BW_DIM{1'b0}}) || (n > DIM_W)) begin
            return DIM_W;
        end else begin
            return n;
        end
    endfunction

    // Acceptance: RUN state, a free credit (or one returning now), and every requested side handshake.
    always_comb begin
        step_ready_s = 1'b0;
        if (!rst && (state_r == ST_RUN) &&
            ((count_r < CNT_MAX) || wresp) &&
            (!step_opcode[1] || fill_valid) &&
            (!step_opcode[2] || lsu_req_ready)) begin
            step_ready_s = 1'b1;
        end else begin
            step_ready_s = 1'b0;
        end
    end

    assign accept_s      = step_valid & step_ready_s;
    assign step_ready    = step_ready_s;
    assign lsu_req_valid = accept_s & step_opcode[2];
    assign fill_ready    = accept_s & step_opcode[1];
    assign rows_s        = eff_dim(num_row);
    assign cols_s        = eff_dim(num_col);

    // Element select (zero > fill > transpose > pass-through) and active-region mask.
    always_comb begin
        data_s = {BW_MATRIX{1'b0}};
        mask_s = {NUM_ELEM{1'b0}};
        for (int r = 0; r < MATRIX_SIZE_PARA; r++) begin
            for (int c = 0; c < MATRIX_SIZE_PARA; c++) begin
                if (step_opcode[3]) begin
                    data_s[(r*MATRIX_SIZE_PARA+c)*BW_SCALAR +: BW_SCALAR] = {BW_SCALAR{1'b0}};
                end else if (step_opcode[1]) begin
                    data_s[(r*MATRIX_SIZE_PARA+c)*BW_SCALAR +: BW_SCALAR] = fill_value;
                end else if (step_opcode[0]) begin
                    data_s[(r*MATRIX_SIZE_PARA+c)*BW_SCALAR +: BW_SCALAR] =
                        src_matrix[(c*MATRIX_SIZE_PARA+r)*BW_SCALAR +: BW_SCALAR];
                end else begin
                    data_s[(r*MATRIX_SIZE_PARA+c)*BW_SCALAR +: BW_SCALAR] =
                        src_matrix[(r*MATRIX_SIZE_PARA+c)*BW_SCALAR +: BW_SCALAR];
                end
                mask_s[r*MATRIX_SIZE_PARA+c] = (BW_DIM'(r) < rows_s) && (BW_DIM'(c) < cols_s);
            end
        end
    end

    // Block-level next-state: DONE waits for every credit back and the final write strobe gone.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (accept_s && step_last) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if ((count_r == {BW_CNT{1'b0}}) && !wvalid_r) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_DONE: state_nxt_s = ST_RUN;
            default: state_nxt_s = ST_RUN;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Credit counter and sticky underflow flag; simultaneous accept and response cancel out.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {BW_CNT{1'b0}};
            err_r   <= 1'b0;
        end else begin
            if (accept_s && !wresp) begin
                count_r <= count_r + BW_CNT'(1'b1);
            end else if (!accept_s && wresp && (count_r != {BW_CNT{1'b0}})) begin
                count_r <= count_r - BW_CNT'(1'b1);
            end else begin
                count_r <= count_r;
            end
            if (!accept_s && wresp && (count_r == {BW_CNT{1'b0}})) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end
        end
    end

    // Registered write port toward the mreg.
    always_ff @(posedge clk) begin
        if (rst) begin
            wvalid_r  <= 1'b0;
            wdata_r   <= {BW_MATRIX{1'b0}};
            wenable_r <= {NUM_ELEM{1'b0}};
        end else begin
            wvalid_r <= accept_s;
            if (accept_s) begin
                wdata_r   <= data_s;
                wenable_r <= mask_s;
            end else begin
                wdata_r   <= wdata_r;
                wenable_r <= wenable_r;
            end
        end
    end

    assign wvalid        = wvalid_r;
    assign wdata         = wdata_r;
    assign wenable       = wenable_r;
    assign err_underflow = err_r;
    assign done          = (state_r == ST_DONE);
    assign busy          = (state_r != ST_RUN) | (count_r != {BW_CNT{1'b0}}) | wvalid_r;

`ifdef DCA_MRU_STEP_STAT_EN
    logic [31:0] stat_steps_r;
    logic [31:0] stat_stall_r;

    // Saturating block statistics, restarted when a block completes.
    always_ff @(posedge clk) begin
        if (rst || (state_r == ST_DONE)) begin
            stat_steps_r <= 32'd0;
            stat_stall_r <= 32'd0;
        end else begin
            if (accept_s && (stat_steps_r != 32'hFFFF_FFFF)) begin
                stat_steps_r <= stat_steps_r + 32'd1;
            end else begin
                stat_steps_r <= stat_steps_r;
            end
            if (step_valid && !step_ready_s && (state_r == ST_RUN) &&
                (stat_stall_r != 32'hFFFF_FFFF)) begin
                stat_stall_r <= stat_stall_r + 32'd1;
            end else begin
                stat_stall_r <= stat_stall_r;
            end
        end
    end

    assign stat_steps = stat_steps_r;
    assign stat_stall = stat_stall_r;
`endif

endmodule

// File: tb/tb_dca_mru_step_engine.sv
// Directed bench for dca_mru_step_engine: a vector table for single-step data/mask cases plus
// hand-written sequences for credit stall, handshakes, drain/done and reset/underflow.
module tb_dca_mru_step_engine;

    localparam int DIM = 8;
    localparam int BW  = 16;
    localparam int NE  = DIM * DIM;
    localparam int BWM = NE * BW;

    logic            clk = 1'b0;
    logic            rst;
    logic            step_valid;
    logic            step_ready;
    logic [3:0]      step_opcode;
    logic            step_last;
    logic [3:0]      num_row;
    logic [3:0]      num_col;
    logic            fill_valid;
    logic            fill_ready;
    logic [BW-1:0]   fill_value;
    logic            lsu_req_valid;
    logic            lsu_req_ready;
    logic [BWM-1:0]  src_matrix;
    logic            wvalid;
    logic [BWM-1:0]  wdata;
    logic [NE-1:0]   wenable;
    logic            wresp;
    logic            busy;
    logic            done;
    logic            err_underflow;
`ifdef DCA_MRU_STEP_STAT_EN
    logic [31:0]     stat_steps;
    logic [31:0]     stat_stall;
`endif

    always #5 clk = ~clk;

    dca_mru_step_engine #(
        .MATRIX_SIZE_PARA(8), .BW_SCALAR(16), .MAX_OUTSTANDING(4), .BW_DIM(4)
    ) dut (
        .clk(clk), .rst(rst),
        .step_valid(step_valid), .step_ready(step_ready), .step_opcode(step_opcode),
        .step_last(step_last), .num_row(num_row), .num_col(num_col),
        .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_value(fill_value),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
        .src_matrix(src_matrix),
        .wvalid(wvalid), .wdata(wdata), .wenable(wenable), .wresp(wresp),
        .busy(busy), .done(done), .err_underflow(err_underflow)
`ifdef DCA_MRU_STEP_STAT_EN
        , .stat_steps(stat_steps), .stat_stall(stat_stall)
`endif
    );

    typedef struct {
        logic [3:0]    op;
        logic [3:0]    nr;
        logic [3:0]    nc;
        logic [15:0]   fv;
        logic [63:0]   exp_mask;
    } vec_t;

    vec_t vecs[10];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   done_seen = 0;

    always @(negedge clk) begin
        if (done === 1'b1) done_seen++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic chk_data(input string name, input logic [BWM-1:0] act, input logic [BWM-1:0] exp);
        int bad;
        bad = -1;
        for (int i = NE - 1; i >= 0; i--) begin
            if (act[i*BW +: BW] !== exp[i*BW +: BW]) bad = i;
        end
        n_chk++;
        if (bad < 0) n_pass++;
        else $display("FAIL %s: element %0d got %0h expected %0h",
                      name, bad, act[bad*BW +: BW], exp[bad*BW +: BW]);
    endtask

    // Reference for a ramp source (element i holds i).
    function automatic logic [BWM-1:0] exp_data(input logic [3:0] op, input logic [15:0] fv);
        logic [BWM-1:0] d;
        d = '0;
        for (int i = 0; i < NE; i++) begin
            if (op[3])      d[i*BW +: BW] = 16'h0000;
            else if (op[1]) d[i*BW +: BW] = fv;
            else if (op[0]) d[i*BW +: BW] = 16'((i % DIM) * DIM + (i / DIM));
            else            d[i*BW +: BW] = 16'(i);
        end
        return d;
    endfunction

    initial begin
        int acc;
        int first_done;
        int base_done;

        rst = 1'b1; step_valid = 1'b0; step_opcode = 4'd0; step_last = 1'b0;
        num_row = 4'd0; num_col = 4'd0; fill_valid = 1'b0; fill_value = 16'h0;
        lsu_req_ready = 1'b0; wresp = 1'b0;
        for (int i = 0; i < NE; i++) src_matrix[i*BW +: BW] = 16'(i);

        vecs[0] = '{op: 4'h0, nr: 4'd0,  nc: 4'd0,  fv: 16'h0000, exp_mask: 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[1] = '{op: 4'h1, nr: 4'd3,  nc: 4'd2,  fv: 16'h0000, exp_mask: 64'h0000_0000_0003_0303};
        vecs[2] = '{op: 4'h2, nr: 4'd8,  nc: 4'd1,  fv: 16'h1234, exp_mask: 64'h0101_0101_0101_0101};
        vecs[3] = '{op: 4'h8, nr: 4'd1,  nc: 4'd8,  fv: 16'h0000, exp_mask: 64'h0000_0000_0000_00FF};
        vecs[4] = '{op: 4'h9, nr: 4'd15, nc: 4'd15, fv: 16'h0000, exp_mask: 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[5] = '{op: 4'h3, nr: 4'd5,  nc: 4'd0,  fv: 16'hBEEF, exp_mask: 64'h0000_00FF_FFFF_FFFF};
        vecs[6] = '{op: 4'h4, nr: 4'd9,  nc: 4'd3,  fv: 16'h0000, exp_mask: 64'h0707_0707_0707_0707};
        vecs[7] = '{op: 4'h5, nr: 4'd2,  nc: 4'd4,  fv: 16'h0000, exp_mask: 64'h0000_0000_0000_0F0F};
        vecs[8] = '{op: 4'hF, nr: 4'd8,  nc: 4'd8,  fv: 16'h7777, exp_mask: 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[9] = '{op: 4'hA, nr: 4'd0,  nc: 4'd7,  fv: 16'h5555, exp_mask: 64'h7F7F_7F7F_7F7F_7F7F};

        // Reset: even with a fully enabled request, nothing is offered or accepted.
        @(negedge clk);
        step_valid = 1'b1; step_opcode = 4'h6; fill_valid = 1'b1; lsu_req_ready = 1'b1;
        @(negedge clk); #1;
        chk("rst_step_ready", 64'(step_ready), 64'd0);
        chk("rst_fill_ready", 64'(fill_ready), 64'd0);
        chk("rst_lsu_valid", 64'(lsu_req_valid), 64'd0);
        chk("rst_wvalid", 64'(wvalid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err_underflow), 64'd0);
        @(negedge clk);
        rst = 1'b0; step_valid = 1'b0; step_opcode = 4'h0;

        // Single-step vectors: accept, check write one cycle later, return the credit.
        for (int v = 0; v < 10; v++) begin
            @(negedge clk);
            step_valid = 1'b1; step_opcode = vecs[v].op; num_row = vecs[v].nr;
            num_col = vecs[v].nc; fill_value = vecs[v].fv;
            #1;
            chk($sformatf("v%0d_ready", v), 64'(step_ready), 64'd1);
            chk($sformatf("v%0d_fill_ready", v), 64'(fill_ready), 64'(vecs[v].op[1]));
            chk($sformatf("v%0d_lsu_valid", v), 64'(lsu_req_valid), 64'(vecs[v].op[2]));
            @(negedge clk);
            step_valid = 1'b0; wresp = 1'b1;
            #1;
            chk($sformatf("v%0d_wvalid", v), 64'(wvalid), 64'd1);
            chk($sformatf("v%0d_wenable", v), wenable, vecs[v].exp_mask);
            chk_data($sformatf("v%0d_wdata", v), wdata, exp_data(vecs[v].op, vecs[v].fv));
            @(negedge clk);
            wresp = 1'b0;
            #1;
            chk($sformatf("v%0d_wvalid_pulse", v), 64'(wvalid), 64'd0);
            chk($sformatf("v%0d_busy", v), 64'(busy), 64'd0);
        end

        // Credit stall: four writes outstanding block further steps until a response returns.
        step_opcode = 4'h0; num_row = 4'd0; num_col = 4'd0;
        acc = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            step_valid = 1'b1;
            #1;
            if (step_ready) acc++;
        end
        chk("credit_accepts", 64'(acc), 64'd4);
        chk("credit_stalled", 64'(step_ready), 64'd0);
        @(negedge clk);
        wresp = 1'b1;
        #1;
        chk("credit_wresp_ready", 64'(step_ready), 64'd1);
        @(negedge clk);
        wresp = 1'b0;
        #1;
        chk("credit_still_full", 64'(step_ready), 64'd0);
        step_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); wresp = 1'b1;
            @(negedge clk); wresp = 1'b0;
        end
        #1;
        chk("credit_drained_busy", 64'(busy), 64'd0);
        chk("credit_no_err", 64'(err_underflow), 64'd0);

        // Handshakes: fill+lsu step waits on lsu_req_ready.
        @(negedge clk);
        step_valid = 1'b1; step_opcode = 4'h6; fill_value = 16'h00AB;
        fill_valid = 1'b1; lsu_req_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("hs_blocked_ready%0d", k), 64'(step_ready), 64'd0);
            chk($sformatf("hs_blocked_fill%0d", k), 64'(fill_ready), 64'd0);
            chk($sformatf("hs_blocked_lsu%0d", k), 64'(lsu_req_valid), 64'd0);
            @(negedge clk);
        end
        lsu_req_ready = 1'b1;
        #1;
        chk("hs_fill_ready", 64'(fill_ready), 64'd1);
        chk("hs_lsu_valid", 64'(lsu_req_valid), 64'd1);
        @(negedge clk);
        step_valid = 1'b0; wresp = 1'b1;
        #1;
        chk("hs_wvalid", 64'(wvalid), 64'd1);
        chk_data("hs_wdata", wdata, exp_data(4'h2, 16'h00AB));
        @(negedge clk);
        wresp = 1'b0;
        #1;
        chk("hs_single_accept", 64'(wvalid), 64'd0);

        // Drain: three steps, last flagged, responses delayed; done pulses exactly once.
        base_done = done_seen;
        step_opcode = 4'h0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            step_valid = 1'b1; step_last = (k == 2);
        end
        @(negedge clk);
        step_last = 1'b0;
        #1;
        chk("drain_ready_low", 64'(step_ready), 64'd0);
        step_valid = 1'b0;
        for (int k = 0; k < 4; k++) @(negedge clk);
        #1;
        chk("drain_busy", 64'(busy), 64'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); wresp = 1'b1;
            @(negedge clk); wresp = 1'b0;
        end
        first_done = -1;
        for (int j = 0; j < 6; j++) begin
            #1;
            if (done && first_done < 0) first_done = j;
            @(negedge clk);
        end
        chk("drain_done_cycle", 64'(first_done), 64'd1);
        chk("drain_done_count", 64'(done_seen - base_done), 64'd1);
        chk("drain_idle", 64'(busy), 64'd0);

        // Underflow, then reset in the middle of a drain.
        @(negedge clk);
        wresp = 1'b1;
        @(negedge clk);
        wresp = 1'b0;
        #1;
        chk("uf_err_set", 64'(err_underflow), 64'd1);
        @(negedge clk);
        #1;
        chk("uf_err_sticky", 64'(err_underflow), 64'd1);
        step_valid = 1'b1; step_last = 1'b1;
        @(negedge clk);
        step_valid = 1'b0; step_last = 1'b0; rst = 1'b1;
        #1;
        chk("mid_drain_busy", 64'(busy), 64'd1);
        base_done = done_seen;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_clears_err", 64'(err_underflow), 64'd0);
        chk("rst_clears_busy", 64'(busy), 64'd0);
        chk("rst_clears_wvalid", 64'(wvalid), 64'd0);
        for (int j = 0; j < 5; j++) @(negedge clk);
        chk("rst_no_done", 64'(done_seen - base_done), 64'd0);
        wresp = 1'b1;
        @(negedge clk);
        wresp = 1'b0;
        #1;
        chk("rst_count_zero", 64'(err_underflow), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
